// File: rtl/spart_driver_if.sv
// spart_driver_if: SPART CPU-side control strobes and queue status flags
interface spart_driver_if;
  logic       iocs_n;
  logic       iorw_n;
  logic [1:0] ioaddr;
  logic       tx_q_full;
  logic       rx_q_empty;
  modport master(output iocs_n, iorw_n, ioaddr, input tx_q_full, rx_q_empty);
  modport slave(input iocs_n, iorw_n, ioaddr, output tx_q_full, rx_q_empty);
endinterface

// File: rtl/spart_driver.sv
// spart_driver: SPART bus master that programs the baud divisor and echoes RX bytes back to TX
module spart_driver #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    br_cfg,
  input  logic          en,
  spart_driver_if.master bus,
  inout  wire  [7:0]    databus,
  output logic          cfg_done,
  output logic [15:0]   echo_cnt
);
  localparam logic [15:0] DIV0 = 16'(CLK_HZ / 4800);
  localparam logic [15:0] DIV1 = 16'(CLK_HZ / 9600);
  localparam logic [15:0] DIV2 = 16'(CLK_HZ / 57600);
  localparam logic [15:0] DIV3 = 16'(CLK_HZ / 230400);
  typedef enum logic [2:0] {POLL, CFG_LO, CFG_HI, RD, WR} state_e;
  state_e      state_q, state_d;
  logic [1:0]  sync0_q, sync1_q, sel_q, sel_d, cur_q, addr_q, addr_d;
  logic        cur_vld_q, cs_n_q, rw_n_q, done_q, wr_d;
  logic [7:0]  hold_q, hold_d, dout_q, dout_d;
  logic [15:0] div, cnt_q;
  always_ff @(posedge clk) begin
    sync0_q <= br_cfg;
    sync1_q <= sync0_q;
  end
  // cur_vld_q clear after reset forces a configuration pass regardless of cfg_cur
  always_comb begin
    state_d = state_q;
    case (state_q)
      CFG_LO:     state_d = CFG_HI;
      CFG_HI, WR: state_d = POLL;
      RD:         state_d = WR;
      default:    state_d = (!cur_vld_q || sync1_q != cur_q) ? CFG_LO :
                            (en && !bus.rx_q_empty && !bus.tx_q_full) ? RD : POLL;
    endcase
    sel_d  = (state_d == CFG_LO) ? sync1_q : sel_q;
    div    = (sel_d == 2'd0) ? DIV0 : (sel_d == 2'd1) ? DIV1 : (sel_d == 2'd2) ? DIV2 : DIV3;
    hold_d = (state_q == RD) ? databus : hold_q;
    wr_d   = state_d inside {CFG_LO, CFG_HI, WR};
    addr_d = (state_d == CFG_LO) ? 2'b10 : (state_d == CFG_HI) ? 2'b11 : 2'b00;
    dout_d = (state_d == CFG_LO) ? div[7:0] : (state_d == CFG_HI) ? div[15:8] : hold_d;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= POLL;
      sel_q     <= '0;
      cur_q     <= '0;
      cur_vld_q <= 1'b0;
      cs_n_q    <= 1'b1;
      rw_n_q    <= 1'b1;
      addr_q    <= '0;
      hold_q    <= '0;
      dout_q    <= '0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cur_q     <= (state_q == CFG_HI) ? sel_q : cur_q;
      cur_vld_q <= cur_vld_q | (state_q == CFG_HI);
      cs_n_q    <= (state_d == POLL);
      rw_n_q    <= !wr_d;
      addr_q    <= addr_d;
      hold_q    <= hold_d;
      dout_q    <= dout_d;
      done_q    <= (state_d == CFG_LO) ? 1'b0 : (state_q == CFG_HI) ? 1'b1 : done_q;
      cnt_q     <= cnt_q + {15'd0, state_q == WR};
    end
  end
  assign databus    = !rw_n_q ? dout_q : 8'bz;
  assign bus.iocs_n = cs_n_q;
  assign bus.iorw_n = rw_n_q;
  assign bus.ioaddr = addr_q;
  assign cfg_done   = done_q;
  assign echo_cnt   = cnt_q;
endmodule

// File: tb/tb_spart_driver.sv
// tb_spart_driver: directed + randomized bench against a byte-stream SPART model
`define CHK(tag, obs, exp) \
  n_chk++; \
  assert ((obs) === (exp)) else begin n_fail++; $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); end

module tb_spart_driver;
  localparam int CLK_HZ = 50_000_000;
  logic        clk = 1'b0, rst = 1'b1, en = 1'b1, tx_full = 1'b0;
  logic [1:0]  br_cfg = 2'b10;
  logic        cfg_done;
  logic [15:0] echo_cnt;
  wire  [7:0]  databus;
  spart_driver_if sif();
  logic [7:0]  rx_mem [512];
  logic [7:0]  tx_log [512];
  logic [15:0] div_tab [4] = '{16'h28B0, 16'h1458, 16'h0364, 16'h00D9};
  logic [15:0] db_model = 16'h0000;
  logic [7:0]  tb_dat = 8'h00;
  int n_push = 0, n_pop = 0, n_tx = 0, n_dacc = 0, n_viol = 0;
  int n_chk = 0, n_fail = 0;
  wire [3:0] bus_st = {sif.iocs_n, sif.iorw_n, sif.ioaddr};

  spart_driver #(.CLK_HZ(CLK_HZ)) dut (
    .clk(clk), .rst(rst), .br_cfg(br_cfg), .en(en), .bus(sif),
    .databus(databus), .cfg_done(cfg_done), .echo_cnt(echo_cnt)
  );

  always #5 clk = ~clk;

  assign databus = sif.iocs_n ? 8'h00 : (sif.iorw_n && sif.ioaddr == 2'b00) ? tb_dat : 8'bz;
  assign sif.rx_q_empty = (n_push == n_pop);
  assign sif.tx_q_full  = tx_full;

  always @(negedge clk) if (!rst && !sif.iocs_n) begin
    if (sif.ioaddr == 2'b01) n_viol++;
    if (sif.ioaddr == 2'b00) n_dacc++;
    if (sif.iorw_n) begin
      if (sif.ioaddr != 2'b00 || n_pop == n_push) n_viol++;
      else begin tb_dat = rx_mem[n_pop]; n_pop++; end
    end else begin
      if ($isunknown(databus)) n_viol++;
      case (sif.ioaddr)
        2'b00:   begin tx_log[n_tx] = databus; n_tx++; end
        2'b10:   db_model[7:0] = databus;
        2'b11:   db_model[15:8] = databus;
        default: ;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_chk(string tag, logic met);
    n_chk++;
    if (!met) begin
      n_fail++;
      $error("TIMEOUT %s: wait expired before condition was met", tag);
    end
  endtask

  initial begin
    logic seen;
    int snap;
    repeat (4) tick();
    n_chk++;
    if (sif.iocs_n !== 1'b1 || sif.iorw_n !== 1'b1 || sif.ioaddr !== 2'b00 ||
        databus !== 8'h00 || cfg_done !== 1'b0 || echo_cnt !== 16'h0000) begin
      n_fail++;
      $error("FAIL reset_state: bus %b data %0h cfg_done %b echo_cnt %0h",
             bus_st, databus, cfg_done, echo_cnt);
    end
    `CHK("rst_iocs_n", sif.iocs_n, 1'b1)
    `CHK("rst_iorw_n", sif.iorw_n, 1'b1)
    `CHK("rst_ioaddr", sif.ioaddr, 2'b00)
    `CHK("rst_bus_released", databus, 8'h00)
    `CHK("rst_cfg_done", cfg_done, 1'b0)
    `CHK("rst_echo_cnt", echo_cnt, 16'h0000)
    rst = 1'b0;
    tick();
    `CHK("cfg_lo_bus", bus_st, 4'b0010)
    `CHK("cfg_lo_data", databus, div_tab[2][7:0])
    `CHK("cfg_lo_done", cfg_done, 1'b0)
    tick();
    `CHK("cfg_hi_bus", bus_st, 4'b0011)
    `CHK("cfg_hi_data", databus, div_tab[2][15:8])
    tick();
    `CHK("cfg_done_c3", cfg_done, 1'b1)
    `CHK("poll_idle", sif.iocs_n, 1'b1)
    `CHK("db_57600", db_model, div_tab[2])

    rx_mem[n_push] = 8'hA5; n_push++;
    rx_mem[n_push] = 8'h3C; n_push++;
    for (int k = 0; k < 50 && n_tx < 2; k++) tick();
    wait_chk("echo2_wait", n_tx >= 2);
    `CHK("echo2_count", n_tx, 2)
    `CHK("echo_b0", tx_log[0], 8'hA5)
    `CHK("echo_b1", tx_log[1], 8'h3C)
    `CHK("echo_cnt2", echo_cnt, 16'd2)
    `CHK("poll_bus_released", databus, 8'h00)
    tick();

    tx_full = 1'b1;
    rx_mem[n_push] = 8'hC3; n_push++;
    seen = 1'b0;
    repeat (10) begin tick(); seen |= !sif.iocs_n; end
    `CHK("full_no_access", seen, 1'b0)
    tx_full = 1'b0;
    tick();
    `CHK("full_rel_rd", bus_st, 4'b0100)
    tick();
    `CHK("full_rel_wr", bus_st, 4'b0000)
    `CHK("full_rel_data", databus, 8'hC3)
    tick();
    `CHK("echo_cnt3", echo_cnt, 16'd3)

    rx_mem[n_push] = 8'h5A; n_push++;
    tick();
    `CHK("rd_5a", bus_st, 4'b0100)
    br_cfg = 2'b11;
    tick();
    `CHK("wr_5a_bus", bus_st, 4'b0000)
    `CHK("wr_5a_data", databus, 8'h5A)
    for (int k = 0; k < 10 && cfg_done; k++) tick();
    wait_chk("reconf_start_wait", !cfg_done);
    `CHK("reconf_started", cfg_done, 1'b0)
    `CHK("reconf_lo_bus", bus_st, 4'b0010)
    `CHK("reconf_lo_data", databus, div_tab[3][7:0])
    `CHK("echo_before_cfg", n_tx, 4)
    for (int k = 0; k < 10 && !cfg_done; k++) tick();
    wait_chk("reconf_done_wait", cfg_done);
    `CHK("reconf_done", cfg_done, 1'b1)
    `CHK("db_230400", db_model, div_tab[3])
    `CHK("echo_cnt4", echo_cnt, 16'd4)

    en = 1'b0;
    snap = n_dacc;
    for (int i = 0; i < 3; i++) begin rx_mem[n_push] = 8'($urandom); n_push++; end
    repeat (20) tick();
    `CHK("en0_no_data_access", n_dacc, snap)
    `CHK("en0_echo_cnt", echo_cnt, 16'd4)
    en = 1'b1;
    for (int k = 0; k < 40 && n_tx < 7; k++) tick();
    wait_chk("en1_drain_wait", n_tx >= 7);
    tick();
    `CHK("en1_drained", n_tx, 7)
    for (int i = 4; i < 7; i++) begin
      `CHK("en1_byte", tx_log[i], rx_mem[i])
    end
    `CHK("en1_echo_cnt", echo_cnt, 16'd7)

    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: begin rx_mem[n_push] = 8'($urandom); n_push++; end
        5, 6, 7:       tx_full = ~tx_full;
        8:             br_cfg = 2'($urandom);
        default:       ;
      endcase
      repeat ($urandom_range(1, 4)) tick();
    end
    tx_full = 1'b0;
    repeat (8) tick();
    for (int k = 0; k < 600 && !(n_tx == n_push && cfg_done); k++) tick();
    wait_chk("rand_drain_wait", n_tx == n_push && cfg_done);
    `CHK("rand_drained", n_tx, n_push)
    seen = 1'b0;
    for (int i = 0; i < n_push; i++) if (tx_log[i] !== rx_mem[i]) seen = 1'b1;
    `CHK("rand_order", seen, 1'b0)
    `CHK("rand_echo_cnt", echo_cnt, 16'(n_push))
    `CHK("rand_db", db_model, div_tab[br_cfg])
    `CHK("rand_cfg_done", cfg_done, 1'b1)
    `CHK("protocol_clean", n_viol, 0)

    rx_mem[n_push] = 8'h99; n_push++;
    for (int k = 0; k < 10 && bus_st != 4'b0000; k++) tick();
    wait_chk("wr_wait", bus_st == 4'b0000);
    `CHK("wr_reached", bus_st, 4'b0000)
    #1 rst = 1'b1;
    #1;
    `CHK("arst_iocs_n", sif.iocs_n, 1'b1)
    `CHK("arst_bus_released", databus, 8'h00)
    `CHK("arst_echo_cnt", echo_cnt, 16'h0000)
    `CHK("arst_cfg_done", cfg_done, 1'b0)
    repeat (3) tick();
    rst = 1'b0;
    tick();
    `CHK("rerun_cfg_lo_bus", bus_st, 4'b0010)
    `CHK("rerun_cfg_lo_data", databus, div_tab[br_cfg][7:0])

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
